time_display_scan: RTL and testbench
====================================

# time_display_scan

Downstream consumer of the time counter: takes the binary `seconds`/`minutes`/`hours` values produced in the 1 Hz domain and drives a 6-digit multiplexed common-anode 7-segment display (HH MM SS) from the fast system clock. It synchronises the counter outputs across the clock boundary and converts them to BCD once per display frame. It scans the digits with a blanking gap between slots to suppress ghosting, and flashes the colon dots for the first half of every second.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `REFRESH_HZ`, 1000, per-digit slot rate; slot length `DIV = CLK_HZ/REFRESH_HZ` cycles, so `DIV >= BLANK_CYCLES+1` is required.
- `BLANK_CYCLES`, 16, cycles at the start of each slot with all anodes off.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `seconds`  in  6  binary seconds, asynchronous to `Clk`.
- `minutes`  in  6  binary minutes, asynchronous to `Clk`.
- `hours`  in  5  binary hours, asynchronous to `Clk`.
- `an`  out  6  digit enables, active low; bit i = digit i.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `dp`  out  1  decimal point (colon dot), active low.

## Operation
- One clock, `Clk`. Reset is asynchronous and active-low on `reset_n`. All registers clear on assertion and release synchronously on the next `Clk` edge.
- Digit map: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hr ones, 5 = hr tens.
- CDC: the 17-bit bundle {hours, minutes, seconds} passes through a 2-flop synchroniser. The stable register loads the synchronised bundle only on a cycle where it equals the previous cycle's synchronised bundle (all 17 bits). Mid-transition mixtures are never captured.
- Snapshot: on each frame boundary (digit index wraps 5→0, and at the first frame after reset), the stable value is converted to BCD and registered. Digits stay frozen for the whole frame.
- Conversion: `tens = v/10`, `ones = v%10`.
  - Out-of-range field (seconds > 59, minutes > 59, hours > 23) shows dash (`7'b0111111`) on both of its digits.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Scan: slot counter runs 0..DIV-1, then digit index increments (5 wraps to 0).
  - Slot cycles 0..BLANK_CYCLES-1: `an = 6'b111111`, `seg = 7'b1111111`, `dp = 1`.
  - Remaining slot cycles: `an[idx] = 0`, `seg` = code of digit idx.
- Colon: a change in the stable seconds value loads the colon timer with `CLK_HZ/2`; the timer decrements to 0 and holds there.
  - `dp = 0` only while the timer is nonzero, a digit is lit, and idx is 2 or 4. Otherwise `dp = 1`.
- Reset mid-operation: outputs go to reset values immediately; scan restarts at idx 0, slot count 0.

## Timing
- Reset values:
  - `an = 6'b111111`, `seg = 7'b1111111`, `dp = 1`
  - idx = 0, slot count = 0, colon timer = 0
  - sync, stable and snapshot registers = 0 (display reads 00 00 00)
- All outputs are registered: they change one cycle after the internal counter/idx state that selects them.
- Input-to-stable latency: 3 `Clk` cycles after the inputs settle.
- Input-to-display latency: at most 3 + 6·DIV + 1 cycles.
- Frame period: exactly 6·DIV cycles. Each digit is lit for DIV−BLANK_CYCLES cycles per frame.
- At no cycle is more than one `an` bit low; adjacent lit digits are separated by at least BLANK_CYCLES dark cycles.
- Colon lit window: starts 4 cycles after a seconds input change and lasts `CLK_HZ/2` cycles. A new change while the timer is running reloads it.

## Test plan
Bench parameters: `CLK_HZ=1000`, `REFRESH_HZ=100` (DIV=10), `BLANK_CYCLES=2`.
- Reset: hold `reset_n=0` with inputs 12:34:56, release → outputs at reset values while low. The first frame shows 00:00:00; frames after the first boundary show digits 5..0 = 1,2,3,4,5,6, with `seg` for digit 0 = 0000010.
- Scan shape: run 3 frames → each `an` bit low for 8 consecutive cycles per 60-cycle frame, order 0→5, 2 dark cycles between, never two bits low.
- Wrap values: input 23:59:59 then change to 00:00:00 mid-frame → the current frame still shows 23:59:59; the next frame shows 00:00:00. No mixed frame.
- Invalid field: hours=24, minutes=7, seconds=61 → digits 5,4 and 1,0 = 0111111; digits 3,2 = 0 (1000000) and 7 (1111000).
- Colon: toggle seconds 5→6 → `dp=0` only during lit slots of digits 2 and 4 for 500 cycles, then `dp=1` until the next seconds change.
- CDC glitch: change hours one cycle before minutes/seconds settle → the stable register never holds the intermediate bundle, checked by an assertion on every load.

Source files
------------

// File: rtl/time_display_scan_if.sv
`timescale 1ns/1ps
// Bundle between the time counter / display pins and the scan driver.
// The master side supplies the binary time fields and receives the
// multiplexed 7-segment drive. The slave side is the display scanner.
interface time_display_scan_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output seconds,
    output minutes,
    output hours,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  seconds,
    input  minutes,
    input  hours,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/time_display_scan.sv
`timescale 1ns/1ps
// Six-digit multiplexed common-anode 7-segment driver (HH MM SS).
// The binary time fields arrive from a slow, unrelated clock domain. They are
// synchronised, accepted only once they are seen to be steady, converted to
// BCD once per frame and scanned out one digit per slot. Each slot begins
// with a dark gap so the previous digit's segments never ghost onto the next.
// The colon dots (dp on digits 2 and 4) flash for the first half second after
// every change of the seconds value.
module time_display_scan #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              reset_n,
  time_display_scan_if.slave disp
);

  localparam int DIV    = CLK_HZ / REFRESH_HZ;
  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF_S = CLK_HZ / 2;
  localparam int TMR_W  = (HALF_S > 0) ? $clog2(HALF_S + 1) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(HALF_S);
  localparam logic [2:0]        IDX_LAST   = 3'd5;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

  // Split a binary field into {out_of_range, tens, ones}. An out-of-range
  // field returns zero digits with the flag set so both its digits show dashes.
  function automatic logic [8:0] to_bcd(input logic [5:0] v, input logic [5:0] v_max);
    if (v > v_max) begin
      return {1'b1, 8'h00};
    end
    return {1'b0, 4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // ---------------------------------------------------------------------
  // Clock-domain crossing: {hours, minutes, seconds}
  // ---------------------------------------------------------------------
  logic [16:0] bundle_in;
  logic [16:0] sync_p0;
  logic [16:0] sync_p1;
  logic [16:0] stable_p2;
  logic        stable_load;
  logic        sec_change;

  assign bundle_in = {disp.hours, disp.minutes, disp.seconds};

  // The stable copy only takes a bundle that two consecutive synchroniser
  // samples agree on, so a half-updated mixture of fields (the source
  // counter rippling from one value to the next) is never accepted.
  assign stable_load = (sync_p0 == sync_p1);
  assign sec_change  = stable_load && (sync_p1[5:0] != stable_p2[5:0]);

  // Two-flop synchroniser followed by the agreement-gated stable register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
    end else begin
      sync_p0 <= bundle_in;
      sync_p1 <= sync_p0;
      if (stable_load) begin
        stable_p2 <= sync_p1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scan timing: slot counter and digit index
  // ---------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        idx;
  logic              started;
  logic              slot_last;
  logic              frame_wrap;
  logic              snap_load;
  logic              lit;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_last && (idx == IDX_LAST);
  // A fresh snapshot is taken as the index wraps back to digit 0, and once
  // on the very first cycle after reset so the first frame is well defined.
  assign snap_load  = frame_wrap || !started;
  assign lit        = (slot_cnt >= SLOT_BLANK);

  // Slot counter runs 0..DIV-1; the digit index steps 0..5 at each slot end.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      idx      <= '0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame snapshot: BCD digits frozen for a whole frame
  // ---------------------------------------------------------------------
  logic [8:0]      sec_bcd;
  logic [8:0]      min_bcd;
  logic [8:0]      hr_bcd;
  logic [5:0][3:0] bcd_p3;
  logic [2:0]      dash_p3;

  // Convert the stable time fields; range limits differ per field.
  always_comb begin
    sec_bcd = to_bcd(stable_p2[5:0], 6'd59);
    min_bcd = to_bcd(stable_p2[11:6], 6'd59);
    hr_bcd  = to_bcd({1'b0, stable_p2[16:12]}, 6'd23);
  end

  // Digit order in bcd_p3 matches the digit index: 0 = sec ones .. 5 = hr tens.
  // dash_p3 holds one out-of-range flag per field: 0 = sec, 1 = min, 2 = hr.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_p3  <= '0;
      dash_p3 <= '0;
    end else if (snap_load) begin
      bcd_p3  <= {hr_bcd[7:0], min_bcd[7:0], sec_bcd[7:0]};
      dash_p3 <= {hr_bcd[8], min_bcd[8], sec_bcd[8]};
    end
  end

  // ---------------------------------------------------------------------
  // Colon flash timer
  // ---------------------------------------------------------------------
  logic [TMR_W-1:0] colon_tmr;

  // Reloaded with half a second on every accepted seconds change, then
  // counts down and parks at zero. A change mid-count restarts the flash.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      colon_tmr <= '0;
    end else if (sec_change) begin
      colon_tmr <= TMR_LOAD;
    end else if (colon_tmr != '0) begin
      colon_tmr <= colon_tmr - TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: registered pin drive
  // ---------------------------------------------------------------------
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [5:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  // Select the drive for the current slot; the blanking gap is all-dark.
  always_comb begin
    an_nxt  = 6'b111111;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(6'b000001 << idx);
      seg_nxt = dash_p3[idx[2:1]] ? SEG_DASH : seg_code(bcd_p3[idx]);
      dp_nxt  = !((colon_tmr != '0) && ((idx == 3'd2) || (idx == 3'd4)));
    end
  end

  // Register every pin so the display sees glitch-free drive.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 6'b111111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
`timescale 1ns/1ps
// Directed bench for time_display_scan with a short slot (DIV = 10,
// 2 blank cycles, 60-cycle frame, 500-cycle colon flash).
module tb_time_display_scan;

  localparam int CLK_HZ     = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int BLANK      = 2;
  localparam int FRAME      = 60;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;

  time_display_scan_if ifc();

  time_display_scan #(
    .CLK_HZ      (CLK_HZ),
    .REFRESH_HZ  (REFRESH_HZ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .Clk    (Clk),
    .reset_n(reset_n),
    .disp   (ifc.slave)
  );

  always #5 Clk = ~Clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]      h;
    logic [5:0]      m;
    logic [5:0]      s;
    logic [5:0][6:0] codes;   // index = digit (0 = sec ones)
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    ifc.hours   = h;
    ifc.minutes = m;
    ifc.seconds = s;
  endtask

  task automatic wait_an(input logic [5:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (ifc.an == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Record the segment code shown on each digit over one frame. When not
  // aligned, first waits for the start of a digit-0 slot; when aligned, the
  // current sample is already the first lit cycle of digit 0.
  task automatic capture_frame(input bit aligned, output logic [5:0][6:0] codes,
                               output int incons, output bit ok);
    logic [5:0] seen;
    codes  = '1;
    incons = 0;
    seen   = '0;
    ok     = 1'b1;
    if (!aligned) begin
      wait_an(6'h3F, 200, ok);
      if (ok) wait_an(6'h3E, 200, ok);
    end
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) @(negedge Clk);
        for (int d = 0; d < 6; d++) begin
          if (ifc.an == ~(6'b000001 << d)) begin
            if (!seen[d]) begin
              seen[d]  = 1'b1;
              codes[d] = ifc.seg;
            end else if (codes[d] != ifc.seg) begin
              incons++;
            end
          end
        end
      end
    end
  endtask

  task automatic expect_frame(input string name, input bit aligned, input logic [5:0][6:0] exp);
    logic [5:0][6:0] got;
    int incons;
    bit ok;
    capture_frame(aligned, got, incons, ok);
    check({name, "_found"}, 32'(ok), 32'd1);
    check({name, "_steady"}, 32'(incons), 32'd0);
    for (int d = 0; d < 6; d++)
      check($sformatf("%s_d%0d", name, d), 32'(got[d]), 32'(exp[d]));
  endtask

  task automatic settle();
    logic [5:0][6:0] junk;
    int incons;
    bit ok;
    capture_frame(1'b0, junk, incons, ok);
    check("settle_found", 32'(ok), 32'd1);
  endtask

  // Samples after reset release until the first lit digit appears.
  task automatic check_first_lit(input string name);
    int first_lit;
    first_lit = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (ifc.an != 6'h3F) begin
        first_lit = k;
        break;
      end
    end
    check({name, "_cycle"}, 32'(first_lit), 32'd3);
    check({name, "_an"}, 32'(ifc.an), 32'h3E);
  endtask

  task automatic scan_shape();
    bit ok;
    int onehot_err, bad_runs, runs, run_len, run_dig, last_dig, dark, cur;
    logic [5:0] low;
    onehot_err = 0; bad_runs = 0; runs = 0; run_len = 0;
    run_dig = -1; last_dig = -1; dark = 0;
    wait_an(6'h3F, 200, ok);
    if (ok) wait_an(6'h3E, 200, ok);
    check("scan_found", 32'(ok), 32'd1);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i > 0) @(negedge Clk);
      low = ~ifc.an;
      if ($countones(low) > 1) onehot_err++;
      if (low == 6'd0) begin
        if (run_len > 0) begin
          if (run_len != 8) bad_runs++;
          runs++;
          last_dig = run_dig;
          run_len = 0;
          dark = 0;
        end
        dark++;
      end else begin
        cur = 0;
        for (int d = 5; d >= 0; d--) if (low[d]) cur = d;
        if (run_len > 0 && cur != run_dig) begin
          bad_runs++;
          runs++;
          last_dig = run_dig;
          run_len = 0;
          dark = 0;
        end
        if (run_len == 0) begin
          if (last_dig < 0) begin
            if (cur != 0) bad_runs++;
          end else if (dark != BLANK || cur != (last_dig + 1) % 6) begin
            bad_runs++;
          end
          run_dig = cur;
        end
        run_len++;
      end
    end
    check("scan_onehot", 32'(onehot_err), 32'd0);
    check("scan_runs_shape", 32'(bad_runs), 32'd0);
    check("scan_run_count", 32'(runs), 32'd18);
  endtask

  task automatic wrap_test();
    bit ok;
    logic [5:0][6:0] got;
    int incons;
    set_time(5'd23, 6'd59, 6'd59);
    settle();
    wait_an(6'b111011, 200, ok);
    check("wrap_found", 32'(ok), 32'd1);
    set_time(5'd0, 6'd0, 6'd0);
    got = '1;
    incons = 0;
    for (int d = 2; d < 6; d++) got[d] = 7'h00;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge Clk);
      if (ifc.an == 6'h3E) break;
      for (int d = 2; d < 6; d++) begin
        if (ifc.an == ~(6'b000001 << d)) begin
          if (got[d] == 7'h00) got[d] = ifc.seg;
          else if (got[d] != ifc.seg) incons++;
        end
      end
    end
    check("wrap_cur_steady", 32'(incons), 32'd0);
    check("wrap_cur_d2", 32'(got[2]), 32'(S9));
    check("wrap_cur_d3", 32'(got[3]), 32'(S5));
    check("wrap_cur_d4", 32'(got[4]), 32'(S3));
    check("wrap_cur_d5", 32'(got[5]), 32'(S2));
    check("wrap_next_start", 32'(ifc.an), 32'h3E);
    expect_frame("wrap_next", 1'b1, {S0, S0, S0, S0, S0, S0});
  endtask

  // CDC watch: every change of the stable register is inspected while armed.
  bit          glitch_watch  = 1'b0;
  logic [16:0] glitch_bundle = '0;
  logic [16:0] last_stable   = '0;
  int          stable_loads  = 0;

  always @(negedge Clk) begin
    if (glitch_watch && dut.stable_p2 !== last_stable) begin
      stable_loads++;
      check("cdc_no_mixture", 32'(dut.stable_p2 == glitch_bundle), 32'd0);
    end
    last_stable = dut.stable_p2;
  end

  task automatic glitch_test();
    set_time(5'd12, 6'd34, 6'd56);
    repeat (10) @(negedge Clk);
    check("cdc_before", 32'(dut.stable_p2), 32'({5'd12, 6'd34, 6'd56}));
    glitch_bundle = {5'd13, 6'd34, 6'd56};
    stable_loads  = 0;
    glitch_watch  = 1'b1;
    ifc.hours = 5'd13;
    @(negedge Clk);
    ifc.minutes = 6'd35;
    ifc.seconds = 6'd57;
    repeat (10) @(negedge Clk);
    glitch_watch = 1'b0;
    check("cdc_load_count", 32'(stable_loads), 32'd1);
    check("cdc_after", 32'(dut.stable_p2), 32'({5'd13, 6'd35, 6'd57}));
    settle();
    expect_frame("cdc_disp", 1'b0, {S1, S3, S3, S5, S5, S7});
  endtask

  task automatic colon_test();
    int idle_low, errs, lows;
    bit in_win, on24, exp_dp;
    set_time(5'd0, 6'd0, 6'd5);
    repeat (600) @(negedge Clk);
    idle_low = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge Clk);
      if (ifc.dp == 1'b0) idle_low++;
    end
    check("colon_idle_dark", 32'(idle_low), 32'd0);
    set_time(5'd0, 6'd0, 6'd6);
    errs = 0;
    lows = 0;
    for (int k = 1; k <= 700; k++) begin
      @(negedge Clk);
      in_win = (k >= 4) && (k <= 503);
      on24   = (ifc.an == 6'b111011) || (ifc.an == 6'b101111);
      exp_dp = !(in_win && on24);
      if (ifc.dp != exp_dp) errs++;
      if (ifc.dp == 1'b0) lows++;
    end
    check("colon_dp_pattern", 32'(errs), 32'd0);
    check("colon_lit_cycles", 32'(lows >= 128), 32'd1);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{h: 5'd12, m: 6'd34, s: 6'd56, codes: {S1, S2, S3, S4, S5, S6}};
    vecs[1] = '{h: 5'd23, m: 6'd59, s: 6'd59, codes: {S2, S3, S5, S9, S5, S9}};
    vecs[2] = '{h: 5'd0,  m: 6'd0,  s: 6'd0,  codes: {S0, S0, S0, S0, S0, S0}};
    vecs[3] = '{h: 5'd24, m: 6'd7,  s: 6'd61, codes: {SD, SD, S0, S7, SD, SD}};
    vecs[4] = '{h: 5'd9,  m: 6'd48, s: 6'd17, codes: {S0, S9, S4, S8, S1, S7}};
    vecs[5] = '{h: 5'd23, m: 6'd60, s: 6'd0,  codes: {S2, S3, SD, SD, S0, S0}};

    // Reset held with a valid time on the inputs.
    set_time(5'd12, 6'd34, 6'd56);
    reset_n = 1'b0;
    repeat (5) @(negedge Clk);
    check("reset_an", 32'(ifc.an), 32'h3F);
    check("reset_seg", 32'(ifc.seg), 32'h7F);
    check("reset_dp", 32'(ifc.dp), 32'd1);
    reset_n = 1'b1;
    check_first_lit("reset_first_lit");
    expect_frame("reset_frame0", 1'b1, {S0, S0, S0, S0, S0, S0});
    expect_frame("reset_frame2", 1'b0, {S1, S2, S3, S4, S5, S6});

    scan_shape();

    for (int i = 0; i < 6; i++) begin
      set_time(vecs[i].h, vecs[i].m, vecs[i].s);
      settle();
      expect_frame($sformatf("vec%0d", i), 1'b0, vecs[i].codes);
    end

    wrap_test();
    glitch_test();
    colon_test();

    // Asynchronous reset in the middle of a lit slot.
    wait_an(6'b110111, 200, ok);
    check("midreset_found", 32'(ok), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_an", 32'(ifc.an), 32'h3F);
    check("midreset_seg", 32'(ifc.seg), 32'h7F);
    check("midreset_dp", 32'(ifc.dp), 32'd1);
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    check_first_lit("midreset_first_lit");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
